// File: rtl/dpcm_decoder.sv
// dpcm_decoder: rebuilds absolute samples from signed residuals (predictor + residual),
// with the predictor restarting at 0 every FRAME_LEN residuals; results queue in an output FIFO.
// Latency: one cycle from accept to out_valid into an empty FIFO. in_ready = !full (registered).
// Optional feature macro: DPCM_DEC_SATURATE_EN (clamp to 0..2^SAMPLE_W-1, sticky sat_flag).
module dpcm_decoder #(
  parameter int DIFF_W    = 4,
  parameter int SAMPLE_W  = 8,
  parameter int FRAME_LEN = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIFF_W-1:0]   data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                frame_start,
  output logic                sat_flag
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef DPCM_DEC_SATURATE_EN
  // Two extra bits: a sign bit plus headroom so max base + positive residual is not read as negative.
  localparam int SW = SAMPLE_W + 2;
`else
  // Wrap mode only needs the low SAMPLE_W bits; the adder truncates naturally.
  localparam int SW = SAMPLE_W;
`endif

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0] pred_q, pred_d;
  logic [SAMPLE_W-1:0] last_dat_q, last_dat_d;
  logic                last_fs_q, last_fs_d;
  logic [SAMPLE_W-1:0] mem_dat_q [OUT_DEPTH];
  logic [SAMPLE_W-1:0] mem_dat_d [OUT_DEPTH];
  logic                mem_fs_q  [OUT_DEPTH];
  logic                mem_fs_d  [OUT_DEPTH];

  logic                push;
  logic                pop;
  logic                first;
  logic [SW-1:0]       base;
  logic [SW-1:0]       resid;
  logic [SW-1:0]       sum;
  logic [SAMPLE_W-1:0] result;
`ifdef DPCM_DEC_SATURATE_EN
  logic                sat_q, sat_d;
  logic                clamp;
`endif

  // Handshake status comes only from the registered count.
  assign in_ready  = (count_q != CW'(OUT_DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Reconstruct the sample for the residual currently offered.
  always_comb begin
    first = (frame_cnt_q == '0);
    base  = first ? '0 : SW'(pred_q);
    resid = {{(SW - DIFF_W){data[DIFF_W-1]}}, data};
    sum   = base + resid;
`ifdef DPCM_DEC_SATURATE_EN
    clamp  = 1'b0;
    result = sum[SAMPLE_W-1:0];
    if (sum[SW-1]) begin
      result = '0;
      clamp  = 1'b1;
    end else if (sum[SW-2]) begin
      result = '1;
      clamp  = 1'b1;
    end
`else
    result = sum;
`endif
  end

  // Next-state for pointers, occupancy, framing, predictor and held output.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    frame_cnt_d = frame_cnt_q;
    pred_d      = pred_q;
    last_dat_d  = last_dat_q;
    last_fs_d   = last_fs_q;
    mem_dat_d   = mem_dat_q;
    mem_fs_d    = mem_fs_q;
`ifdef DPCM_DEC_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (push) begin
      mem_dat_d[wr_ptr_q] = result;
      mem_fs_d[wr_ptr_q]  = first;
      wr_ptr_d            = wr_ptr_q + 1'b1;
      pred_d              = result;
      frame_cnt_d         = (frame_cnt_q == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt_q + 1'b1;
`ifdef DPCM_DEC_SATURATE_EN
      sat_d               = sat_q | clamp;
`endif
    end
    if (pop) begin
      // Remember the departing head so the outputs hold it once the FIFO drains.
      last_dat_d = mem_dat_q[rd_ptr_q];
      last_fs_d  = mem_fs_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
      pred_q      <= '0;
      last_dat_q  <= '0;
      last_fs_q   <= 1'b0;
`ifdef DPCM_DEC_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      pred_q      <= pred_d;
      last_dat_q  <= last_dat_d;
      last_fs_q   <= last_fs_d;
`ifdef DPCM_DEC_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // FIFO storage; contents are only visible through count, so no reset needed.
  always_ff @(posedge clock) begin
    mem_dat_q <= mem_dat_d;
    mem_fs_q  <= mem_fs_d;
  end

  // Head entry while valid, otherwise the last sample shown.
  always_comb begin
    out_data    = last_dat_q;
    frame_start = last_fs_q;
    if (out_valid) begin
      out_data    = mem_dat_q[rd_ptr_q];
      frame_start = mem_fs_q[rd_ptr_q];
    end
  end

`ifdef DPCM_DEC_SATURATE_EN
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

endmodule
